// File: rtl/ram_ctrl.sv
// Byte-wide RAM controller with a fixed one-cycle request/response port.
// Optional memory-mapped output FIFO at 0x3xxxx is built when RAM_CTRL_MMIO_EN is defined.
module ram_ctrl #(
  parameter int unsigned AddrWidth    = 17,
  parameter int unsigned FifoDepthLog = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_valid_from_ft,
  input  logic        is_store_from_ft,
  input  logic [31:0] addr_from_ft,
  input  logic [7:0]  data_from_ft,
  output logic [7:0]  data_to_ft,
  output logic        is_ready_to_ft,
  output logic        is_stall_to_ft,
  output logic [7:0]  io_data,
  output logic        io_valid,
  input  logic        io_ready
);

  localparam int unsigned RamBytes  = 1 << AddrWidth;
  localparam int unsigned FifoDepth = 1 << FifoDepthLog;
  localparam int unsigned CntWidth  = FifoDepthLog + 1;

  logic                 stall_c;
  logic                 accept_c;
  logic                 is_io_c;
  logic                 ram_we_c;
  logic [AddrWidth-1:0] ram_addr_c;
  logic [7:0]           io_rdata_c;

  logic [7:0]           ram_q [RamBytes];
  logic                 ready_q, ready_d;
  logic [7:0]           data_q, data_d;

  logic                 unused_c;

  assign accept_c   = is_valid_from_ft & ~stall_c;
  assign ram_addr_c = addr_from_ft[AddrWidth-1:0];
  assign ram_we_c   = accept_c & is_store_from_ft & ~is_io_c;

  // Upper address bits only matter for the I/O decode; io_ready is idle without the FIFO.
  assign unused_c = ^{addr_from_ft[31:AddrWidth], io_ready};

`ifdef RAM_CTRL_MMIO_EN
  logic                    push_c;
  logic                    pop_c;
  logic [7:0]              fifo_q [FifoDepth];
  logic [FifoDepthLog-1:0] head_q, head_d;
  logic [FifoDepthLog-1:0] tail_q, tail_d;
  logic [CntWidth-1:0]     count_q, count_d;
  logic                    stall_q, stall_d;

  assign is_io_c    = (addr_from_ft[17:16] == 2'b11);
  assign push_c     = accept_c & is_store_from_ft & is_io_c & (addr_from_ft[17:0] == 18'h30000);
  assign pop_c      = io_valid & io_ready;
  assign io_rdata_c = (addr_from_ft[17:0] == 18'h30004) ? 8'(count_q) : 8'h00;

  assign io_valid   = (count_q != '0);
  assign io_data    = fifo_q[head_q];
  assign stall_c    = stall_q;

  // Pointer/occupancy next state; a pop from empty cannot occur since io_valid gates it.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_c) tail_d = tail_q + FifoDepthLog'(1);
    if (pop_c)  head_d = head_q + FifoDepthLog'(1);
    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
    stall_d = (count_d == CntWidth'(FifoDepth));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[tail_q] <= data_from_ft;
  end
`else
  assign is_io_c    = 1'b0;
  assign io_rdata_c = 8'h00;
  assign io_valid   = 1'b0;
  assign io_data    = 8'h00;
  assign stall_c    = 1'b0;
`endif

  // RAM array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (ram_we_c) ram_q[ram_addr_c] <= data_from_ft;
  end

  always_comb begin
    ready_d = accept_c;
    data_d  = data_q;
    if (accept_c && !is_store_from_ft) begin
      data_d = is_io_c ? io_rdata_c : ram_q[ram_addr_c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

  // A reset arriving in the response cycle swallows the pending completion pulse.
  assign is_ready_to_ft = ready_q & rst;
  assign is_stall_to_ft = stall_c;
  assign data_to_ft     = data_q;

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
- REQ-001 Parameter AddrWidth, default 17, RAM byte-address width (2^AddrWidth bytes).
- REQ-002 Parameter FifoDepthLog, default 3, log2 of I/O output FIFO depth (8 entries).
- REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
- REQ-004 Port rst  input  1  synchronous, active-low reset.
- REQ-005 Port is_valid_from_ft  input  1  request strobe from fetcher, one cycle per byte.
- REQ-006 Port is_store_from_ft  input  1  1 = byte store, 0 = byte load.
- REQ-007 Port addr_from_ft  input  32  byte address.
- REQ-008 Port data_from_ft  input  8  store byte.
- REQ-009 Port data_to_ft  output  8  load byte, registered.
- REQ-010 Port is_ready_to_ft  output  1  one-cycle completion pulse per accepted request.
- REQ-011 Port is_stall_to_ft  output  1  requests are not accepted while high.
- REQ-012 Port io_data  output  8  head byte of I/O FIFO.
- REQ-013 Port io_valid  output  1  I/O FIFO non-empty.
- REQ-014 Port io_ready  input  1  downstream transmitter consumes head byte when io_valid && io_ready.

Function
- REQ-015 Request accepted in cycle N iff is_valid_from_ft=1 and is_stall_to_ft=0; otherwise ignored, no is_ready pulse.
- REQ-016 Accepted request yields is_ready_to_ft=1 in cycle N+1 only; fixed latency 1, back-to-back acceptance every cycle.
- REQ-017 RAM load: data_to_ft in N+1 = RAM[addr_from_ft[AddrWidth-1:0]]; upper address bits ignored for RAM.
- REQ-018 RAM store: RAM byte written at edge ending cycle N; load to same address in N+1 returns new byte.
- REQ-019 data_to_ft holds last value between responses; store responses leave data_to_ft unchanged.
- REQ-020 I/O region (MMIO_EN only): addr_from_ft[17:16]==2'b11.
- REQ-021 I/O store to 0x30000: push data_from_ft into FIFO tail.
- REQ-022 I/O load from 0x30004: data_to_ft = zero-extended FIFO occupancy; other I/O loads return 8'h00; other I/O stores are discarded but still acknowledged.
- REQ-023 FIFO pop when io_valid && io_ready; head pointer increments, wraps modulo depth.
- REQ-024 Simultaneous push and pop: both performed, occupancy unchanged; on empty FIFO, push only (io_valid rises next cycle).
- REQ-025 Occupancy counter FifoDepthLog+1 bits, 0..2^FifoDepthLog.
- REQ-026 is_stall_to_ft registered, =1 when occupancy after this cycle's update equals full depth; deasserts the cycle after a pop from full.
- REQ-027 Stall applies to all requests, RAM included (single in-order request port).
- REQ-028 io_data/io_valid driven directly from FIFO storage/occupancy, no extra latency.

Reset
- REQ-029 rst=0 at a rising edge: is_ready_to_ft=0, is_stall_to_ft=0, data_to_ft=8'h00, FIFO pointers and occupancy=0 (io_valid=0).
- REQ-030 RAM contents are not cleared by reset.
- REQ-031 Reset mid-operation: a request accepted in the cycle before reset produces no is_ready pulse; FIFO contents discarded.

Configuration
- REQ-032 Macro RAM_CTRL_MMIO_EN defined: I/O region, FIFO, io_* ports active as above.
- REQ-033 Macro undefined: all addresses map to RAM, FIFO not built, io_valid=0, io_data=8'h00, is_stall_to_ft=0 permanently; io_ready ignored.

Verification
- REQ-034 Store 8'hA5 to 0x00010, load 0x00010 next cycle -> is_ready pulses in both following cycles, second data_to_ft=8'hA5.
- REQ-035 Load 0x20010 after storing 8'h3C to 0x00010 -> data_to_ft=8'h3C (address aliasing above AddrWidth).
- REQ-036 MMIO_EN, io_ready=0, eight stores to 0x30000 -> is_stall_to_ft=1 after eighth; ninth request ignored, no is_ready.
- REQ-037 From full, io_ready=1 one cycle -> io_data sequence first byte, occupancy 7, is_stall_to_ft=0 next cycle; load 0x30004 returns 8'h07.
- REQ-038 FIFO with 3 entries, push and pop same cycle -> occupancy stays 3, FIFO order preserved across pointer wrap.
- REQ-039 Accept a load, assert rst=0 next cycle -> no is_ready pulse, data_to_ft=8'h00, io_valid=0.
